gp_line_sequencer: RTL

//  Upstream feeder for the line engine. Pulls 32-bit graphics command words from a command FIFO.

---
 rtl/gp_line_sequencer_pkg.sv | 31 +++
 rtl/gp_line_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/gp_line_sequencer_pkg.sv
// gp_line_sequencer_pkg: command opcodes, FSM encodings and field helpers for the line sequencer.
package gp_line_sequencer_pkg;

  localparam logic [7:0] GP_OP_NOP  = 8'h00;
  localparam logic [7:0] GP_OP_LINE = 8'h01;
  localparam logic [7:0] GP_OP_END  = 8'hFF;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR   = 4'd1;
  localparam logic [3:0] S_P0    = 4'd2;
  localparam logic [3:0] S_P1    = 4'd3;
  localparam logic [3:0] S_WAIT  = 4'd4;
  localparam logic [3:0] S_LDCOL = 4'd5;
  localparam logic [3:0] S_LDP0  = 4'd6;
  localparam logic [3:0] S_LDP1  = 4'd7;
  localparam logic [3:0] S_TRIG  = 4'd8;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } point_t;

  function automatic point_t pt_of(input logic [19:0] b);
    return '{x: b[19:10], y: b[9:0]};
  endfunction

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == GP_OP_NOP) || (op == GP_OP_LINE) || (op == GP_OP_END);
  endfunction

endpackage

// File: rtl/gp_line_sequencer.sv
// gp_line_sequencer: pulls command words from the FIFO and drives the line engine's
// colour/point/trigger load sequence, pacing lines on LE_ready.
module gp_line_sequencer
  import gp_line_sequencer_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             LE_ready,
  output logic [31:0]      LE_color,
  output logic [19:0]      LE_point,
  output logic             LE_color_valid,
  output logic             LE_point0_valid,
  output logic             LE_point1_valid,
  output logic             LE_trigger,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] line_count
);

  localparam int GW = $clog2(GUARD_CYCLES + 2);

  logic [3:0]    state, state_n;
  logic [GW-1:0] guard;
  logic [23:0]   rgb;
  point_t        pt0, pt1;
  logic [7:0]    op;
  logic          accept, hdr_acc, line_hdr, end_hdr, bad_hdr;

  assign op        = cmd_data[31:24];
  assign cmd_ready = (state == S_HDR) || (state == S_P0) || (state == S_P1);
  assign accept    = cmd_valid && cmd_ready;
  assign hdr_acc   = accept && (state == S_HDR);
  assign line_hdr  = hdr_acc && (op == GP_OP_LINE);
  assign end_hdr   = hdr_acc && (op == GP_OP_END);
  assign bad_hdr   = hdr_acc && !is_known_op(op);
  assign busy      = state != S_IDLE;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_HDR : S_IDLE;
      S_HDR:   state_n = line_hdr ? S_P0 : end_hdr ? S_IDLE : S_HDR;
      S_P0:    state_n = accept ? S_P1 : S_P0;
      S_P1:    state_n = accept ? S_WAIT : S_P1;
      S_WAIT:  state_n = (guard == '0 && LE_ready) ? S_LDCOL : S_WAIT;
      S_LDCOL: state_n = S_LDP0;
      S_LDP0:  state_n = S_LDP1;
      S_LDP1:  state_n = S_TRIG;
      S_TRIG:  state_n = S_HDR;
      default: state_n = S_IDLE;
    endcase
  end

  // Pulses are registered from the next state so each one is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      guard           <= '0;
      rgb             <= '0;
      pt0             <= '0;
      pt1             <= '0;
      LE_color        <= '0;
      LE_point        <= '0;
      LE_color_valid  <= 1'b0;
      LE_point0_valid <= 1'b0;
      LE_point1_valid <= 1'b0;
      LE_trigger      <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      line_count      <= '0;
    end else begin
      state           <= state_n;
      guard           <= (state == S_TRIG) ? GW'(GUARD_CYCLES) : (guard != '0) ? guard - GW'(1) : guard;
      LE_color_valid  <= state_n == S_LDCOL;
      LE_point0_valid <= state_n == S_LDP0;
      LE_point1_valid <= state_n == S_LDP1;
      LE_trigger      <= state_n == S_TRIG;
      done            <= end_hdr;
      if (line_hdr) rgb <= cmd_data[23:0];
      if (accept && state == S_P0) pt0 <= pt_of(cmd_data[19:0]);
      if (accept && state == S_P1) pt1 <= pt_of(cmd_data[19:0]);
      if (state_n == S_LDCOL) LE_color <= {8'h00, rgb};
      if (state_n == S_LDP0) LE_point <= pt0;
      else if (state_n == S_LDP1) LE_point <= pt1;
      if (state == S_IDLE && start) begin
        err        <= 1'b0;
        line_count <= '0;
      end else begin
        if (bad_hdr) err <= 1'b1;
        if (state == S_TRIG) line_count <= line_count + CNT_W'(1);
      end
    end
  end

endmodule
